// File: rtl/downscale_box_stream.sv
// downscale_box_stream: integer X/Y downscaler for RGB565 camera video.
// Emits one decimated or box-averaged pixel per block, tagged with (x,y).
module downscale_box_stream #(
    parameter int IN_W    = 1280,
    parameter int IN_H    = 720,
    parameter int SCALE_X = 3,
    parameter int SCALE_Y = 3,
    parameter int OUT_W   = IN_W / SCALE_X,
    parameter int OUT_H   = IN_H / SCALE_Y,
    parameter int MODE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vs,
    input  logic        in_href,
    input  logic        in_de,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [11:0] out_x,
    output logic [11:0] out_y,
    output logic        frame_done
);

    localparam logic [2:0]  XLAST = 3'(SCALE_X - 1);
    localparam logic [2:0]  YLAST = 3'(SCALE_Y - 1);
    localparam logic [11:0] OW    = 12'(OUT_W);
    localparam logic [11:0] OH    = 12'(OUT_H);
    localparam logic [11:0] OW1   = 12'(OUT_W - 1);
    localparam logic [11:0] OH1   = 12'(OUT_H - 1);

    logic        in_vs_d;
    logic        in_href_d;
    logic        armed;
    logic [2:0]  x_mod;
    logic [2:0]  y_mod;
    logic [11:0] sx;
    logic [11:0] sy;

    logic        vs_rise;
    logic        href_fall;
    logic        pix_ok;
    logic        x_wrap;
    logic        y_wrap;
    logic        last_blk;
    logic        grp_done;
    logic        fin_hit;

    logic        s1_valid;
    logic        s1_final;
    logic [11:0] s1_sx;
    logic [11:0] s1_sy;

    logic        res_emit;
    logic [15:0] res_data;

    assign vs_rise   = in_vs & ~in_vs_d;
    assign href_fall = ~in_href & in_href_d;
    assign x_wrap    = (x_mod == XLAST);
    assign y_wrap    = (y_mod == YLAST);
    assign last_blk  = (sx == OW1) && (sy == OH1);

    // A pixel contributes only while armed and inside the whole-block area
    assign pix_ok = armed && !vs_rise && !href_fall && in_de
                    && (sx < OW) && (sy < OH);

    assign grp_done = pix_ok && ((MODE == 1) ? x_wrap
                                 : (x_mod == 3'd0 && y_mod == 3'd0));
    assign fin_hit  = grp_done && last_blk && (MODE != 1 || y_wrap);

    // Edge detection, arming and block/column/row counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_vs_d   <= 1'b0;
            in_href_d <= 1'b0;
            armed     <= 1'b0;
            x_mod     <= '0;
            y_mod     <= '0;
            sx        <= '0;
            sy        <= '0;
        end else begin
            in_vs_d   <= in_vs;
            in_href_d <= in_href;
            if (vs_rise) begin
                armed <= 1'b1;
                x_mod <= '0;
                y_mod <= '0;
                sx    <= '0;
                sy    <= '0;
            end else if (armed) begin
                if (fin_hit) armed <= 1'b0;
                if (href_fall) begin
                    x_mod <= '0;
                    sx    <= '0;
                    if (y_wrap) begin
                        y_mod <= '0;
                        if (sy != OH) sy <= sy + 12'd1;
                    end else begin
                        y_mod <= y_mod + 3'd1;
                    end
                end else if (in_de) begin
                    if (x_wrap) begin
                        x_mod <= '0;
                        if (sx != OW) sx <= sx + 12'd1;
                    end else begin
                        x_mod <= x_mod + 3'd1;
                    end
                end
            end
        end
    end

    // Stage 1: block/group event with its output coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_final <= 1'b0;
            s1_sx    <= '0;
            s1_sy    <= '0;
        end else begin
            s1_valid <= grp_done;
            if (grp_done) begin
                s1_final <= fin_hit;
                s1_sx    <= sx;
                s1_sy    <= sy;
            end
        end
    end

    if (MODE == 1) begin : g_box
        localparam int N    = SCALE_X * SCALE_Y;
        localparam int LOGN = $clog2(N);
        localparam int RW   = 5 + LOGN;
        localparam int GW   = 6 + LOGN;
        localparam int BW   = 5 + LOGN;
        localparam int SW   = RW + GW + BW;
        localparam int RW1  = RW + 1;
        localparam int GW1  = GW + 1;
        localparam int BW1  = BW + 1;
        localparam int AW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

        logic [RW-1:0] h_r, h_r_n, s1_r, acc_r, tot_r;
        logic [GW-1:0] h_g, h_g_n, s1_g, acc_g, tot_g;
        logic [BW-1:0] h_b, h_b_n, s1_b, acc_b, tot_b;
        logic          s1_first;
        logic          s1_last;
        logic [SW-1:0] acc [OUT_W];
        logic [AW-1:0] acc_idx;

        // Horizontal group sum; the first pixel of a group overwrites it
        always_comb begin
            h_r_n = RW'(in_data[15:11]);
            h_g_n = GW'(in_data[10:5]);
            h_b_n = BW'(in_data[4:0]);
            if (x_mod != 3'd0) begin
                h_r_n = h_r + RW'(in_data[15:11]);
                h_g_n = h_g + GW'(in_data[10:5]);
                h_b_n = h_b + BW'(in_data[4:0]);
            end
        end

        // Running horizontal sums and the completed group handed to stage 1
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                h_r      <= '0;
                h_g      <= '0;
                h_b      <= '0;
                s1_r     <= '0;
                s1_g     <= '0;
                s1_b     <= '0;
                s1_first <= 1'b0;
                s1_last  <= 1'b0;
            end else begin
                if (pix_ok) begin
                    h_r <= h_r_n;
                    h_g <= h_g_n;
                    h_b <= h_b_n;
                end
                if (grp_done) begin
                    s1_r     <= h_r_n;
                    s1_g     <= h_g_n;
                    s1_b     <= h_b_n;
                    s1_first <= (y_mod == 3'd0);
                    s1_last  <= y_wrap;
                end
            end
        end

        assign acc_idx = s1_sx[AW-1:0];
        assign {acc_r, acc_g, acc_b} = acc[acc_idx];

        // Vertical accumulation; the first row of a block overwrites
        always_comb begin
            tot_r = s1_r;
            tot_g = s1_g;
            tot_b = s1_b;
            if (!s1_first) begin
                tot_r = acc_r + s1_r;
                tot_g = acc_g + s1_g;
                tot_b = acc_b + s1_b;
            end
        end

        // Line accumulator write-back (distributed RAM, no reset)
        always_ff @(posedge clk) begin
            if (s1_valid) acc[acc_idx] <= {tot_r, tot_g, tot_b};
        end

        assign res_emit = s1_valid & s1_last;
        assign res_data = {
            5'(({1'b0, tot_r} + RW1'(N / 2)) / RW1'(N)),
            6'(({1'b0, tot_g} + GW1'(N / 2)) / GW1'(N)),
            5'(({1'b0, tot_b} + BW1'(N / 2)) / BW1'(N))
        };
    end else begin : g_dec
        logic [15:0] s1_pix;

        // Capture the top-left pixel of each block
        always_ff @(posedge clk) begin
            if (!rst_n) s1_pix <= '0;
            else if (grp_done) s1_pix <= in_data;
        end

        assign res_emit = s1_valid;
        assign res_data = s1_pix;
    end

    // Stage 2: registered output strobe, pixel and coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= res_emit;
            frame_done <= res_emit & s1_final;
            if (res_emit) begin
                out_data <= res_data;
                out_x    <= s1_sx;
                out_y    <= s1_sy;
            end
        end
    end

endmodule

// File: tb/tb_downscale_box_stream.sv
// tb_downscale_box_stream: random frames into a 3x3 box and a 2x2 decimate
// instance, compared against block arithmetic over the driven frame.
module tb_downscale_box_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vs = 1'b0;
    logic        in_href = 1'b0;
    logic        in_de = 1'b0;
    logic [15:0] in_data = '0;

    logic        b_valid, b_fd, d_valid, d_fd;
    logic [15:0] b_data, d_data;
    logic [11:0] b_x, b_y, d_x, d_y;

    always #5 clk = ~clk;

    downscale_box_stream #(
        .IN_W(12), .IN_H(6), .SCALE_X(3), .SCALE_Y(3), .MODE(1)
    ) u_box (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_href(in_href),
        .in_de(in_de), .in_data(in_data), .out_valid(b_valid),
        .out_data(b_data), .out_x(b_x), .out_y(b_y), .frame_done(b_fd)
    );

    downscale_box_stream #(
        .IN_W(8), .IN_H(4), .SCALE_X(2), .SCALE_Y(2), .MODE(0)
    ) u_dec (
        .clk(clk), .rst_n(rst_n), .in_vs(in_vs), .in_href(in_href),
        .in_de(in_de), .in_data(in_data), .out_valid(d_valid),
        .out_data(d_data), .out_x(d_x), .out_y(d_y), .frame_done(d_fd)
    );

    typedef struct packed {
        int          cyc;
        logic [11:0] x;
        logic [11:0] y;
        logic [15:0] d;
        logic        fd;
    } obs_t;

    obs_t        qb[$];
    obs_t        qd[$];
    obs_t        ex[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          stray = 0;
    logic [15:0] pix [8][16];
    int          dcyc [8][16];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe both instances away from the active edge
    always @(negedge clk) begin
        if (b_valid) qb.push_back('{cyc, b_x, b_y, b_data, b_fd});
        if (d_valid) qd.push_back('{cyc, d_x, d_y, d_data, d_fd});
        if (b_fd && !b_valid) stray++;
        if (d_fd && !d_valid) stray++;
    end

    task automatic rand_pix();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                pix[y][x] = 16'($urandom);
    endtask

    task automatic drive_frame(input int w, input int h,
                               input bit collide, input int rst_line);
        qb.delete();
        qd.delete();
        in_vs = 0; in_href = 0; in_de = 0;
        if (!collide) begin
            @(negedge clk) in_vs = 1;
            @(negedge clk);
            @(negedge clk) in_vs = 0;
        end
        repeat (3) @(negedge clk);
        for (int y = 0; y < h; y++) begin
            if (collide && y == 0) begin
                @(negedge clk);
                in_vs = 1; in_href = 1; in_de = 1; in_data = 16'hDEAD;
            end
            for (int x = 0; x < w; x++) begin
                @(negedge clk);
                if (y == rst_line && x == 5) begin
                    rst_n = 0; qb.delete(); qd.delete();
                end
                if (y == rst_line && x == 8) rst_n = 1;
                in_href = 1; in_de = 1; in_data = pix[y][x];
                dcyc[y][x] = cyc;
            end
            @(negedge clk);
            in_href = 0; in_de = 0; in_vs = 0;
            repeat (3) @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    // 3x3 box average of the top-left 12x6 area, rounded to nearest
    task automatic model_box();
        ex.delete();
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 4; bx++) begin
                int sr, sg, sb;
                obs_t e;
                sr = 0; sg = 0; sb = 0;
                for (int j = 0; j < 3; j++)
                    for (int i = 0; i < 3; i++) begin
                        logic [15:0] p;
                        p = pix[by*3+j][bx*3+i];
                        sr += int'(p[15:11]);
                        sg += int'(p[10:5]);
                        sb += int'(p[4:0]);
                    end
                e.cyc = dcyc[by*3+2][bx*3+2] + 2;
                e.x = 12'(bx);
                e.y = 12'(by);
                e.d = {5'((sr + 4) / 9), 6'((sg + 4) / 9), 5'((sb + 4) / 9)};
                e.fd = (bx == 3 && by == 1);
                ex.push_back(e);
            end
    endtask

    // 2x2 decimation of an 8x4 frame: top-left pixel of each block
    task automatic model_dec();
        ex.delete();
        for (int by = 0; by < 2; by++)
            for (int bx = 0; bx < 4; bx++) begin
                obs_t e;
                e.cyc = dcyc[2*by][2*bx] + 2;
                e.x = 12'(bx);
                e.y = 12'(by);
                e.d = pix[2*by][2*bx];
                e.fd = (bx == 3 && by == 1);
                ex.push_back(e);
            end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({b_valid, b_data, b_x, b_y, b_fd} !== 41'd0) begin
            bad++;
            $display("FAIL reset_box got=%h want=0",
                     {b_valid, b_data, b_x, b_y, b_fd});
        end
        total++;
        if ({d_valid, d_data, d_x, d_y, d_fd} !== 41'd0) begin
            bad++;
            $display("FAIL reset_dec got=%h want=0",
                     {d_valid, d_data, d_x, d_y, d_fd});
        end
        @(negedge clk) rst_n = 1;
        qb.delete();
        qd.delete();
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 12; x++) begin
                @(negedge clk);
                in_href = 1; in_de = 1; in_data = 16'($urandom);
            end
            @(negedge clk) begin in_href = 0; in_de = 0; end
            repeat (3) @(negedge clk);
        end
        total++;
        if (qb.size() + qd.size() != 0) begin
            bad++;
            $display("FAIL disarmed got=%0d strobes want=0",
                     qb.size() + qd.size());
        end
    endtask

    task automatic test_const();
        int nf;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++)
                pix[y][x] = 16'hF81F;
        drive_frame(12, 6, 0, -1);
        model_box();
        total++;
        if (qb.size() != ex.size()) begin
            bad++;
            $display("FAIL const_count got=%0d want=%0d", qb.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qb.size() || qb[i] !== ex[i]) begin
                bad++;
                $display("FAIL const_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qb[i].x, qb[i].y, qb[i].d, qb[i].fd, qb[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
        nf = 0;
        foreach (qb[i]) if (qb[i].d === 16'hF81F) nf++;
        total++;
        if (nf != 8) begin
            bad++;
            $display("FAIL const_value got=%0d pixels of f81f want=8", nf);
        end
    endtask

    task automatic test_round();
        int rv [9] = '{31, 31, 31, 31, 15, 0, 0, 0, 0};
        rand_pix();
        for (int k = 0; k < 9; k++)
            pix[k/3][k%3] = {5'(rv[k]), (k == 0) ? 6'd13 : 6'd0, 5'd0};
        drive_frame(12, 6, 0, -1);
        model_box();
        total++;
        if (qb.size() != ex.size()) begin
            bad++;
            $display("FAIL round_count got=%0d want=%0d", qb.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qb.size() || qb[i] !== ex[i]) begin
                bad++;
                $display("FAIL round_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qb[i].x, qb[i].y, qb[i].d, qb[i].fd, qb[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
        total++;
        if (qb.size() == 0 || qb[0].d !== 16'h7820) begin
            bad++;
            $display("FAIL round_block0 got=%h want=7820", qb[0].d);
        end
    endtask

    task automatic test_decimate();
        bit seen;
        rand_pix();
        pix[0][2] = 16'h1234;
        drive_frame(8, 4, 0, -1);
        model_dec();
        total++;
        if (qd.size() != ex.size()) begin
            bad++;
            $display("FAIL dec_count got=%0d want=%0d", qd.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qd.size() || qd[i] !== ex[i]) begin
                bad++;
                $display("FAIL dec_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qd[i].x, qd[i].y, qd[i].d, qd[i].fd, qd[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
        seen = 0;
        foreach (qd[i])
            if (qd[i].x == 12'd1 && qd[i].y == 12'd0 && qd[i].d === 16'h1234
                && qd[i].cyc == dcyc[0][2] + 2) seen = 1;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL dec_latency got=no 1234 at (1,0) cycle %0d want=1",
                     dcyc[0][2] + 2);
        end
    endtask

    task automatic test_partial();
        rand_pix();
        drive_frame(14, 7, 0, -1);
        model_box();
        total++;
        if (qb.size() != ex.size()) begin
            bad++;
            $display("FAIL part_count got=%0d want=%0d", qb.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qb.size() || qb[i] !== ex[i]) begin
                bad++;
                $display("FAIL part_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qb[i].x, qb[i].y, qb[i].d, qb[i].fd, qb[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_pix();
        drive_frame(12, 6, 0, 4);
        total++;
        if (qb.size() + qd.size() != 0) begin
            bad++;
            $display("FAIL rstmid_quiet got=%0d strobes want=0",
                     qb.size() + qd.size());
        end
        rand_pix();
        drive_frame(12, 6, 0, -1);
        model_box();
        total++;
        if (qb.size() != ex.size()) begin
            bad++;
            $display("FAIL rstmid_count got=%0d want=%0d", qb.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qb.size() || qb[i] !== ex[i]) begin
                bad++;
                $display("FAIL rstmid_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qb[i].x, qb[i].y, qb[i].d, qb[i].fd, qb[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
    endtask

    task automatic test_collide();
        rand_pix();
        drive_frame(12, 6, 1, -1);
        model_box();
        total++;
        if (qb.size() != ex.size()) begin
            bad++;
            $display("FAIL vs_count got=%0d want=%0d", qb.size(), ex.size());
        end
        foreach (ex[i]) begin
            total++;
            if (i >= qb.size() || qb[i] !== ex[i]) begin
                bad++;
                $display("FAIL vs_px%0d got (%0d,%0d) %h fd=%b @%0d want (%0d,%0d) %h fd=%b @%0d",
                         i, qb[i].x, qb[i].y, qb[i].d, qb[i].fd, qb[i].cyc,
                         ex[i].x, ex[i].y, ex[i].d, ex[i].fd, ex[i].cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_round();
        test_decimate();
        test_partial();
        test_reset_mid();
        test_collide();
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL stray_frame_done got=%0d want=0", stray);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/downscale_box_stream.md
# downscale_box_stream

Streaming, parametrised integer downscaler for RGB565 camera video with separate X/Y factors and a selectable decimate or box-average mode. It sits between the camera capture interface and the frame store or BRAM writer, on the camera pixel clock. It emits one output pixel per SCALE_X×SCALE_Y input block, tagged with output coordinates. Output coordinates replace the linear write-address bookkeeping previously done inside the scaler.

## Interface
- IN_W, 1280: active input pixels per line.
- IN_H, 720: active input lines per frame.
- SCALE_X, 3: horizontal factor, legal range 1..8.
- SCALE_Y, 3: vertical factor, legal range 1..8.
- OUT_W, IN_W/SCALE_X: output pixels per line.
- OUT_H, IN_H/SCALE_Y: output lines per frame.
- MODE, 1: 0 selects decimate (top-left pixel of each block); 1 selects box average.
- clk  in  1  camera pixel clock; the block's only clock.
- rst_n  in  1  synchronous reset, active low.
- in_vs  in  1  frame sync; a frame starts on its rising edge. Already synchronous to clk.
- in_href  in  1  line valid; a line ends on its falling edge.
- in_de  in  1  pixel valid.
- in_data  in  16  RGB565 pixel, with R[15:11], G[10:5], B[4:0].
- out_valid  out  1  one-cycle strobe marking an output pixel.
- out_data  out  16  RGB565 result.
- out_x  out  12  output column, 0..OUT_W-1.
- out_y  out  12  output row, 0..OUT_H-1.
- frame_done  out  1  one-cycle pulse together with the last pixel (OUT_W-1, OUT_H-1).

## Operation
- **Counters:** x_mod/y_mod count 0..SCALE-1; sx/sy count output columns/rows. No multipliers or dividers appear in the address path.
- **Edge detection:** in_vs and in_href are each registered once. vs_rise is in_vs & ~in_vs_d; href_fall is ~in_href & in_href_d.
- **Arming:** after reset the block is disarmed. It ignores all input until the first vs_rise, which arms it. A reset asserted mid-frame therefore discards that frame.
- **vs_rise:**
  - Clears x_mod, y_mod, sx and sy.
  - Does not clear the accumulators, because the first line of a group overwrites them.
  - If in_de is high in the same cycle, that pixel is dropped.
- **Each in_de pixel:** x_mod advances, and sx advances when x_mod wraps.
- **Pixels ignored:** pixels with sx ≥ OUT_W, and lines with sy ≥ OUT_H. The partial block at the right edge and partial rows at the bottom are discarded.
- **href_fall:**
  - Clears x_mod and sx.
  - Advances y_mod, and advances sy when y_mod wraps.
  - A partial horizontal group is discarded.
- **MODE=1 (box average):**
  - Per-channel horizontal sum registers accumulate SCALE_X pixels.
  - On group completion, a line accumulator entry acc[sx] (OUT_W entries, distributed RAM, combinational read) is updated:
    - y_mod==0: written with the h-sum.
    - Otherwise: written with acc[sx] + h-sum.
  - On y_mod==SCALE_Y-1 the block emits, per channel, (sum + N/2)/N with integer division, where N = SCALE_X·SCALE_Y.
  - Accumulator widths are 5/6/5 bits plus ceil(log2 N) for R/G/B.
  - A reciprocal-multiply implementation is allowed only if it is bit-exact for every reachable sum.
- **MODE=0 (decimate):** the block emits in_data for the pixel with x_mod==0 and y_mod==0. No accumulator is instantiated.
- **frame_done:** asserted with the out_valid for (OUT_W-1, OUT_H-1). After it, further input is ignored until the next vs_rise.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_x=0, out_y=0, frame_done=0; counters are 0; the block is disarmed.
- **Latency:** if the emitting pixel is on in_de at cycle t, out_valid is high at t+2, with out_data, out_x and out_y valid in the same cycle.
  - MODE=1: the emitting pixel is the last pixel of the block.
  - MODE=0: the emitting pixel is the sampled pixel.
- **Throughput:** out_valid is never high in consecutive cycles unless SCALE_X=1. For SCALE_X=1 it may be high every cycle. No backpressure exists.
- **Accumulator RMW:** when SCALE_X=1, consecutive group completions hit different sx, so no read-after-write hazard on the same entry occurs within a line.
- **Pipeline drain:** the t+1/t+2 pipeline drains regardless of a later href_fall or vs_rise, so the last pixel of a line is still emitted.
- **Reset priority:** rst_n low at any cycle clears the pipeline, so a pending out_valid is not emitted.

## Test plan
- **Constant average:** MODE=1, 3×3, IN_W=12, IN_H=6, every pixel 16'hF81F. Expect 8 strobes, all 16'hF81F, coordinates (0,0)..(3,1), and frame_done with (3,1).
- **Rounding:** MODE=1, 3×3, one block whose R values sum to 139 → R=(139+4)/9=15. G values sum 13 → G=1. B all 0 → B=0.
- **Decimate latency:** MODE=0, 2×2, pixel at x=2,y=0 is 16'h1234 on in_de at cycle t. Expect out_valid at t+2 with out_data=16'h1234, out_x=1, out_y=0. Odd input lines produce no strobes.
- **Partial edges:** MODE=1, 3×3, IN_W=14, drive 14 pixels per line over 7 lines. Expect exactly 4×2 outputs; the trailing 2 columns and 1 row produce nothing.
- **Reset mid-frame:** assert rst_n=0 during line 4, release, and keep streaming. Expect no out_valid until after the next vs_rise; the following frame is correct from (0,0).
- **vs collision:** vs_rise in the same cycle as in_de, followed by a full frame. Expect the coincident pixel dropped and output (0,0) built from the next 3×3 pixels.
